// File: rtl/mure_drain_ctrl.sv
// Drain sequencer for the multiple-retirement ingress FIFOs: presents each retired
// slot of the head entry in ascending order and pops all FIFOs after the last one.
module mure_drain_ctrl #(
  parameter int NrRetiredInstr = 2,
  parameter int CntW           = 16,
  localparam int SelW          = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      empty_i,
  input  logic [NrRetiredInstr-1:0] head_retire_i,
  input  logic                      ready_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  output logic [SelW-1:0]           sel_o,
  output logic                      pop_o,
  output logic                      busy_o,
  output logic [CntW-1:0]           served_cnt_o
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [NrRetiredInstr-1:0] pend_q, pend_d;
  logic [CntW-1:0]           served_q, served_d;

  logic [NrRetiredInstr-1:0] seen;
  logic [NrRetiredInstr-1:0] first;
  logic [NrRetiredInstr-1:0] rest;
  logic [SelW-1:0]           first_idx;

  // One-hot mask of the lowest pending slot via a running "lower bit seen" chain.
  for (genvar gi = 0; gi < NrRetiredInstr; gi++) begin : g_first
    if (gi == 0) begin : g_lsb
      assign seen[gi] = 1'b0;
    end else begin : g_upper
      assign seen[gi] = seen[gi-1] | pend_q[gi-1];
    end
    assign first[gi] = pend_q[gi] & ~seen[gi];
  end

  assign rest = pend_q & ~first;

  always_comb begin
    first_idx = '0;
    for (int i = 0; i < NrRetiredInstr; i++) begin
      if (first[i]) first_idx = SelW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    served_d = served_q;
    valid_o  = 1'b0;
    sel_o    = '0;
    pop_o    = 1'b0;
    busy_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_i) begin
          if (head_retire_i == '0) begin
            pop_o = 1'b1;
          end else begin
            pend_d  = head_retire_i;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy_o  = 1'b1;
        sel_o   = first_idx;
        valid_o = !flush_i;
        // Flush abandons the entry outright; no handshake is counted.
        if (flush_i) begin
          pop_o   = 1'b1;
          pend_d  = '0;
          state_d = IDLE;
        end else if (ready_i) begin
          pend_d   = rest;
          served_d = served_q + CntW'(1);
          if (rest == '0) begin
            pop_o   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      served_q <= served_d;
    end
  end

  assign served_cnt_o = served_q;

endmodule

// File: tb/tb_mure_drain_ctrl.sv
// Bench for mure_drain_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked against a slot-queue model of the drain sequence.
module tb_mure_drain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        empty, ready, flush;
  logic [1:0]  retire;
  logic        valid, pop, busy;
  logic [0:0]  sel;
  logic [15:0] cnt;

  logic        empty2, ready2, flush2;
  logic [3:0]  retire2;
  logic        valid2, pop2, busy2;
  logic [1:0]  sel2;
  logic [3:0]  cnt2;

  mure_drain_ctrl #(.NrRetiredInstr(2), .CntW(16)) dut (
    .clk_i(clk), .rst_i(rst), .empty_i(empty), .head_retire_i(retire),
    .ready_i(ready), .flush_i(flush), .valid_o(valid), .sel_o(sel),
    .pop_o(pop), .busy_o(busy), .served_cnt_o(cnt)
  );

  mure_drain_ctrl #(.NrRetiredInstr(4), .CntW(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .empty_i(empty2), .head_retire_i(retire2),
    .ready_i(ready2), .flush_i(flush2), .valid_o(valid2), .sel_o(sel2),
    .pop_o(pop2), .busy_o(busy2), .served_cnt_o(cnt2)
  );

  // Model: queue of slot indices still to present for the latched entry.
  int q[$];
  int mcnt = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the negedge, compare just after, advance the model at posedge.
  task automatic step(input logic e, input logic [1:0] r, input logic rd, input logic f,
                      input int xv, input int xs, input int xp);
    int eb, ev, es, ep;
    empty = e; retire = r; ready = rd; flush = f;
    #1;
    eb = (q.size() > 0) ? 1 : 0;
    ev = (eb == 1 && !f) ? 1 : 0;
    es = (eb == 1) ? q[0] : 0;
    ep = 0;
    if (eb == 0) begin
      if (!e && r == 2'b00) ep = 1;
    end else if (f) begin
      ep = 1;
    end else if (rd && q.size() == 1) begin
      ep = 1;
    end
    chk("valid", int'(valid), ev);
    chk("sel",   int'(sel),   es);
    chk("pop",   int'(pop),   ep);
    chk("busy",  int'(busy),  eb);
    chk("cnt",   int'(cnt),   mcnt);
    if (xv >= 0) chk("lit_valid", int'(valid), xv);
    if (xs >= 0) chk("lit_sel",   int'(sel),   xs);
    if (xp >= 0) chk("lit_pop",   int'(pop),   xp);
    @(posedge clk);
    if (eb == 0) begin
      if (!e && r != 2'b00) begin
        for (int i = 0; i < 2; i++) if (r[i]) q.push_back(i);
      end
    end else if (f) begin
      q.delete();
    end else if (rd) begin
      void'(q.pop_front());
      mcnt = (mcnt + 1) % 65536;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; empty = 1'b1; retire = 2'b00; ready = 1'b0; flush = 1'b0;
    empty2 = 1'b1; retire2 = 4'h0; ready2 = 1'b0; flush2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_pop",   int'(pop),   0);
    chk("rst_cnt",   int'(cnt),   0);
    rst = 1'b0;

    // Two retired slots, full throughput; empty_i toggled during DRAIN is ignored.
    step(0, 2'b11, 1, 0, 0, 0, 0);
    step(1, 2'b11, 1, 0, 1, 0, 0);
    step(1, 2'b00, 1, 0, 1, 1, 1);
    step(1, 2'b00, 1, 0, 0, 0, 0);
    chk("lit_cnt_both", int'(cnt), 2);

    // Slot 0 not retired: skipped with no cycle cost.
    step(0, 2'b10, 1, 0, 0, 0, 0);
    step(1, 2'b00, 1, 0, 1, 1, 1);
    step(1, 2'b00, 1, 0, 0, 0, 0);
    chk("lit_cnt_skip", int'(cnt), 3);

    // Entry with nothing retired is discarded in one IDLE cycle.
    step(0, 2'b00, 1, 0, 0, 0, 1);
    step(1, 2'b00, 1, 0, 0, 0, 0);
    chk("lit_cnt_empty", int'(cnt), 3);

    // Backpressure holds the selection.
    step(0, 2'b11, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2'b11, 0, 0, 1, 0, 0);
    step(1, 2'b11, 1, 0, 1, 0, 0);
    step(1, 2'b11, 1, 0, 1, 1, 1);
    step(1, 2'b00, 1, 0, 0, 0, 0);
    chk("lit_cnt_bp", int'(cnt), 5);

    // Flush while slot 1 pending beats ready.
    step(0, 2'b11, 1, 0, 0, 0, 0);
    step(1, 2'b00, 1, 0, 1, 0, 0);
    step(1, 2'b00, 1, 1, 0, 1, 1);
    step(1, 2'b00, 1, 0, 0, 0, 0);
    chk("lit_cnt_flush", int'(cnt), 6);

    // Asynchronous reset mid-DRAIN with slot 1 still pending.
    step(0, 2'b11, 1, 0, 0, 0, 0);
    step(1, 2'b00, 1, 0, 1, 0, 0);
    empty = 1'b1; ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_sel",   int'(sel),   0);
    chk("arst_pop",   int'(pop),   0);
    chk("arst_busy",  int'(busy),  0);
    chk("arst_cnt",   int'(cnt),   0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 2'b11, 1, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), -1, -1, -1);
    end

    // Counter wrap on a 4-slot, 4-bit-counter instance: 20 handshakes wrap past 15.
    empty2 = 1'b0; retire2 = 4'hF; ready2 = 1'b1; flush2 = 1'b0;
    n = 0;
    for (int ent = 0; ent < 5; ent++) begin
      for (int j = 0; j < 5; j++) begin
        #1;
        chk("w_cnt",   int'(cnt2),   n % 16);
        chk("w_valid", int'(valid2), (j > 0) ? 1 : 0);
        chk("w_sel",   int'(sel2),   (j > 0) ? j - 1 : 0);
        chk("w_pop",   int'(pop2),   (j == 4) ? 1 : 0);
        if (j > 0) n++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    empty2 = 1'b1;
    #1;
    chk("w_cnt_final", int'(cnt2), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
